// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds FSM state encodings, error codes and word geometry.
package imem_loader_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned ERR_W      = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_COLLECT = 3'd1;
  localparam logic [STATE_W-1:0] S_WRITE   = 3'd2;
  localparam logic [STATE_W-1:0] S_VERIFY  = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd4;
  localparam logic [STATE_W-1:0] S_ERROR   = 3'd5;

  localparam logic [ERR_W-1:0] ERR_NONE = 2'b00;
  localparam logic [ERR_W-1:0] ERR_OVF  = 2'b01;
  localparam logic [ERR_W-1:0] ERR_VFY  = 2'b10;

  // States in which a new start is honoured.
  function automatic logic can_start(input logic [STATE_W-1:0] s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

  // States in which the CPU must be held off.
  function automatic logic is_busy(input logic [STATE_W-1:0] s);
    return (s == S_COLLECT) || (s == S_WRITE) || (s == S_VERIFY);
  endfunction

endpackage

// File: rtl/imem_loader_be_word_packer.sv
// be_word_packer: big-endian byte-to-word shift register.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr_i        synchronous clear of index and partial word
//   shift_en_i   accept byte_i this cycle
//   byte_i       incoming byte (first byte ends up in [31:24])
//   word_o       assembled word
//   word_full_c  combinational pulse: this accepted byte completes the word
module be_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        shift_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_c
);

  logic [31:0]      word_q;
  logic [IDX_W-1:0] idx_q;

  assign word_o      = word_q;
  assign word_full_c = shift_en_i && (idx_q == IDX_W'(WORD_BYTES - 1));

  // Shift MSB first; the index wraps to 0 after the last byte of a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0;
      idx_q  <= '0;
    end else if (clr_i) begin
      word_q <= 32'h0;
      idx_q  <= '0;
    end else if (shift_en_i) begin
      word_q <= {word_q[23:0], byte_i};
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the big-endian instruction memory.
// Packs a byte stream into words, writes each word, reads it back to verify,
// and holds the CPU (busy) until the image is in place.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start, word_count        begin a load of word_count words
//   byte_in/valid/ready      host byte stream handshake
//   im_addr/din/dout         memory address, write data, async read data
//   im_cs/wr/rd              memory strobes
//   busy, done, err          status (done/err hold until next start)
//   err_code, err_addr       failure cause and failing word address
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_din,
  input  logic [31:0]      im_dout,
  output logic             im_cs,
  output logic             im_wr,
  output logic             im_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [31:0]      err_addr
);

  // Bytes available above BASE_ADDR; 33 bits so the compare cannot wrap.
  localparam logic [32:0] CAP_BYTES = 33'(MEM_BYTES) - 33'(BASE_ADDR);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   words_left_q, words_left_d;
  logic [31:0]        addr_q, addr_d;
  logic [ERR_W-1:0]   err_code_q, err_code_d;
  logic [31:0]        err_addr_q, err_addr_d;

  logic        shift_en;
  logic        packer_clr;
  logic [31:0] word;
  logic        word_full;
  logic [32:0] req_bytes;

  assign shift_en  = byte_valid && (state_q == S_COLLECT);
  assign req_bytes = 33'({word_count, 2'b00});

  be_word_packer u_packer (
    .clk         (clk),
    .rst_n       (reset_n),
    .clr_i       (packer_clr),
    .shift_en_i  (shift_en),
    .byte_i      (byte_in),
    .word_o      (word),
    .word_full_c (word_full)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      addr_q       <= 32'h0;
      err_code_q   <= ERR_NONE;
      err_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      err_code_q   <= err_code_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    err_code_d   = err_code_q;
    err_addr_d   = err_addr_q;
    packer_clr   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start && can_start(state_q)) begin
          words_left_d = word_count;
          err_code_d   = ERR_NONE;
          packer_clr   = 1'b1;
          if (word_count == '0) begin
            state_d = S_DONE;
          end else if (req_bytes > CAP_BYTES) begin
            state_d    = S_ERROR;
            err_code_d = ERR_OVF;
            err_addr_d = BASE_ADDR;
          end else begin
            state_d = S_COLLECT;
            addr_d  = BASE_ADDR;
          end
        end
      end
      S_COLLECT: begin
        if (word_full) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (im_dout == word) begin
          words_left_d = words_left_q - CNT_W'(1);
          addr_d       = addr_q + 32'd4;
          if (words_left_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_COLLECT;
            packer_clr = 1'b1;
          end
        end else begin
          state_d    = S_ERROR;
          err_code_d = ERR_VFY;
          err_addr_d = addr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state so strobes drop with reset.
  always_comb begin
    byte_ready = 1'b0;
    im_cs      = 1'b0;
    im_wr      = 1'b0;
    im_rd      = 1'b0;
    im_addr    = 32'h0;
    im_din     = 32'h0;
    busy       = is_busy(state_q);
    done       = (state_q == S_DONE);
    err        = (state_q == S_ERROR);
    err_code   = err_code_q;
    err_addr   = err_addr_q;

    case (state_q)
      S_COLLECT: byte_ready = 1'b1;
      S_WRITE: begin
        im_cs   = 1'b1;
        im_wr   = 1'b1;
        im_addr = addr_q;
        im_din  = word;
      end
      S_VERIFY: begin
        im_cs   = 1'b1;
        im_rd   = 1'b1;
        im_addr = addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time initiator for the processor's byte-addressed, big-endian instruction memory. It takes a byte stream from a host link with a valid/ready handshake and packs each group of four bytes into a 32-bit word, MSB first. Each word is written through the memory's chip-select/write/read port and then read back to verify it. The CPU is held off until the whole image is loaded.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be a multiple of 4.
- MEM_BYTES, 4096, instruction memory capacity in bytes.
- CNT_W, 11, width of word_count; covers 0..1024 words.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless the block is idle, done or in error.
- word_count  in  CNT_W  number of words to load; latched on start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  the loader accepts a byte this cycle.
- im_addr  out  32  memory byte address.
- im_din  out  32  write data to memory.
- im_dout  in  32  read data from memory; asynchronous.
- im_cs, im_wr, im_rd  out  1 each  memory strobes.
- busy  out  1  load in progress; also used as the CPU hold.
- done  out  1  sticky; the load completed and every word verified.
- err  out  1  sticky; the load failed.
- err_code  out  2  01 = capacity overflow, 10 = verify mismatch.
- err_addr  out  32  address of the failing word.

## Operation
States: IDLE, COLLECT, WRITE, VERIFY, DONE, ERROR. Outputs are decoded from the registered state and datapath registers.

- **IDLE, DONE, ERROR**
  - On start, latch word_count into words_left and clear done, err and err_code.
  - count 0: go to DONE.
  - count × 4 > MEM_BYTES − BASE_ADDR: go to ERROR with err_code = 01 and err_addr = BASE_ADDR. No memory access takes place.
  - Otherwise: set addr = BASE_ADDR, byte_idx = 0, and go to COLLECT.
- **COLLECT**
  - byte_ready = 1.
  - Each accepted byte (byte_valid && byte_ready) shifts in as word <= {word[23:0], byte_in} and increments byte_idx.
  - The 4th accepted byte moves the state to WRITE.
- **WRITE** (one cycle)
  - im_cs = im_wr = 1, im_addr = addr, im_din = word, byte_ready = 0.
  - Next state is VERIFY.
- **VERIFY** (one cycle)
  - im_cs = im_rd = 1, im_addr = addr; compare im_dout with word.
  - Match: decrement words_left and add 4 to addr. If words_left was 1, go to DONE; otherwise go to COLLECT with byte_idx = 0.
  - Mismatch: go to ERROR with err_code = 10 and err_addr = addr.
- **Outputs outside WRITE/VERIFY:** im_cs = im_wr = im_rd = 0, im_addr = 0, im_din = 0.
- **busy** is 1 in COLLECT, WRITE and VERIFY.
- **done** is 1 only in DONE; **err** is 1 only in ERROR.
- **Address arithmetic:** addr advances in byte units, +4 per word, 32-bit. The capacity check guarantees no wrap-around.

## Timing
- **Reset values:** state IDLE; every output 0 (byte_ready, im_*, busy, done, err, err_code, err_addr); internal word, addr, byte_idx and words_left all cleared.
- **Reset mid-operation:** all state is dropped immediately, including any partial word, and the memory strobes fall asynchronously.
- **Start latency:** start at cycle t puts the block in COLLECT (or DONE/ERROR) at t+1.
- **Per-word cost:** 4 accepted bytes, then WRITE, then VERIFY. At full stream rate that is 6 cycles per word.
- **Write timing:** the memory captures the word on the posedge that ends WRITE. The VERIFY compare happens in the following cycle.
- **Back-pressure:** byte_ready is 0 during WRITE and VERIFY. A byte presented then is not consumed and must be held by the source.
- **Timing of done/err:** they assert in the cycle after the final VERIFY or the failing check, and stay asserted until the next start.
- **start while busy:** ignored.

## Structure
- A shared package header holds:
  - the state encodings, as 3-bit localparams;
  - ERR_NONE / ERR_OVF / ERR_VFY;
  - WORD_BYTES = 4.
- Sub-module be_word_packer: byte shift register plus 2-bit index, with a word_full pulse and a clear input. The FSM, counters and memory-port driving stay in imem_loader.

## Test plan
- **Two-word load:** count = 2, bytes 12 34 56 78 9A BC DE F0 at full rate, memory model attached. Writes must go to addr 0 = 32'h12345678 and addr 4 = 32'h9ABCDEF0. Memory bytes 0..7 must read back in that big-endian order. done = 1 at cycle 13 after start; busy stays 1 throughout.
- **Zero count:** count = 0 → done = 1 the next cycle; im_cs never asserts.
- **Overflow:** count = 1025 with BASE_ADDR 0 → err = 1, err_code = 01, err_addr = 0; im_wr never asserts.
- **Stalled stream:** byte_valid high only every 3rd cycle, plus a byte offered during WRITE/VERIFY. The same memory contents as the two-word load must result, and no byte may be lost or duplicated.
- **Verify mismatch:** memory model flips bit 0 on reads at addr 4 → err_code = 10, err_addr = 4, done = 0, and no access at addr 8.
- **Mid-load reset:** reset_n pulsed low after 2 bytes of word 0 → all outputs 0 immediately. A following start with count = 1 writes a clean word at BASE_ADDR.
